// File: rtl/robo_motion_arbiter_pkg.sv
// Shared types for the motion arbiter: FSM state encoding, motor command codes and
// the helper that maps the illegal {rot,fwd}=11 request to STOP.
package robo_motion_arbiter_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StAuto   = 3'd1,
        StManual = 3'd2,
        StBrake  = 3'd3,
        StFault  = 3'd4
    } state_e;

    // Motor command, packed as {rot, fwd}
    typedef logic [1:0] cmd_t;

    localparam cmd_t CmdStop = 2'b00;
    localparam cmd_t CmdFwd  = 2'b01;
    localparam cmd_t CmdRot  = 2'b10;

    function automatic cmd_t sanitise_cmd(input logic rot, input logic fwd);
        return (rot && fwd) ? CmdStop : {rot, fwd};
    endfunction

endpackage

// File: rtl/robo_motion_arbiter_if.sv
// Request/command bundle between the two motion sources and the arbiter.
// master: follower + manual controller side; slave: the arbiter.
interface robo_motion_arbiter_if;

    logic auto_avancar;
    logic auto_girar;
    logic man_req;
    logic man_avancar;
    logic man_girar;
    logic fault_clr;
    logic man_grant;
    logic motor_fwd;
    logic motor_rot;
    logic fault;

    modport master (
        output auto_avancar, auto_girar, man_req, man_avancar, man_girar, fault_clr,
        input  man_grant, motor_fwd, motor_rot, fault
    );

    modport slave (
        input  auto_avancar, auto_girar, man_req, man_avancar, man_girar, fault_clr,
        output man_grant, motor_fwd, motor_rot, fault
    );

endinterface

// File: rtl/robo_motion_arbiter_sat_counter.sv
// Saturating up/down counter with synchronous clear and load.
// Priority: clear > load > inc > dec; never wraps in either direction.
module robo_motion_arbiter_sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/robo_motion_arbiter.sv
// Shares the forward/rotate motor commands between the wall-follower and a manual controller,
// with break-before-make handover, per-command dwell and a rotate watchdog for the follower.
module robo_motion_arbiter
    import robo_motion_arbiter_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 4,
    parameter int unsigned ROT_TIMEOUT  = 64,
    parameter int unsigned CNT_W        = 8
) (
    input logic                  clock,
    input logic                  reset,
    robo_motion_arbiter_if.slave bus_io
);

    localparam logic [CNT_W-1:0] DwellLoad = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] RotLast   = CNT_W'(ROT_TIMEOUT - 1);

    state_e           state_d, state_q;
    cmd_t             motor_d, motor_q;
    logic             man_grant_d, man_grant_q;
    logic             fault_d, fault_q;
    cmd_t             sel_cmd;
    logic [CNT_W-1:0] dwell_cnt, rot_cnt;
    logic             dwell_clr, dwell_load, dwell_dec;
    logic             rot_clr, rot_inc;
    logic             wd_expire, stopping, active;

    assign wd_expire = (state_q == StAuto) && motor_q[1] && (rot_cnt == RotLast);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Watchdog expiry outranks a manual takeover request.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   state_d = bus_io.man_req ? StManual : StAuto;
            StAuto: begin
                if (wd_expire) begin
                    state_d = StFault;
                end else if (bus_io.man_req) begin
                    state_d = StBrake;
                end
            end
            StManual: if (!bus_io.man_req) state_d = StBrake;
            StBrake:  state_d = bus_io.man_req ? StManual : StAuto;
            StFault:  if (bus_io.fault_clr) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        sel_cmd = (state_q == StManual) ? sanitise_cmd(bus_io.man_girar, bus_io.man_avancar)
                                        : sanitise_cmd(bus_io.auto_girar, bus_io.auto_avancar);
        active     = (state_q == StAuto) || (state_q == StManual);
        stopping   = (state_d == StBrake) || (state_d == StFault);
        motor_d    = motor_q;
        dwell_clr  = 1'b0;
        dwell_load = 1'b0;
        dwell_dec  = 1'b0;
        if (stopping) begin
            motor_d   = CmdStop;
            dwell_clr = 1'b1;
        end else if (active) begin
            if (dwell_cnt != '0) begin
                dwell_dec = 1'b1;
            end else if (sel_cmd != motor_q) begin
                motor_d    = sel_cmd;
                dwell_load = 1'b1;
            end
        end else begin
            dwell_clr = 1'b1;
        end
        rot_inc     = (state_q == StAuto) && motor_q[1] && !stopping;
        rot_clr     = !rot_inc;
        man_grant_d = (state_d == StManual);
        fault_d     = (state_d == StFault);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            motor_q     <= CmdStop;
            man_grant_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            motor_q     <= motor_d;
            man_grant_q <= man_grant_d;
            fault_q     <= fault_d;
        end
    end

    robo_motion_arbiter_sat_counter #(
        .CNT_W (CNT_W)
    ) u_dwell_cnt (
        .clock      (clock),
        .reset      (reset),
        .clear_i    (dwell_clr),
        .load_i     (dwell_load),
        .load_val_i (DwellLoad),
        .inc_i      (1'b0),
        .dec_i      (dwell_dec),
        .cnt_o      (dwell_cnt)
    );

    robo_motion_arbiter_sat_counter #(
        .CNT_W (CNT_W)
    ) u_rot_cnt (
        .clock      (clock),
        .reset      (reset),
        .clear_i    (rot_clr),
        .load_i     (1'b0),
        .load_val_i ('0),
        .inc_i      (rot_inc),
        .dec_i      (1'b0),
        .cnt_o      (rot_cnt)
    );

    assign bus_io.motor_fwd = motor_q[0];
    assign bus_io.motor_rot = motor_q[1];
    assign bus_io.man_grant = man_grant_q;
    assign bus_io.fault     = fault_q;

endmodule

// File: tb/tb_robo_motion_arbiter.sv
// Directed bench for robo_motion_arbiter: vector table for dwell/handover, then hand-written
// sequences for the watchdog, fault clear and asynchronous reset.
module tb_robo_motion_arbiter;

    logic clock = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    robo_motion_arbiter_if bus ();

    robo_motion_arbiter #(
        .DWELL_CYCLES (4),
        .ROT_TIMEOUT  (64),
        .CNT_W        (8)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .bus_io (bus)
    );

    always #5 clock = ~clock;

    // exp = {man_grant, fault, motor_rot, motor_fwd}; commands are {rot, fwd}
    typedef struct {
        logic [1:0] auto_cmd;
        logic       man_req;
        logic [1:0] man_cmd;
        logic       fault_clr;
        logic [3:0] exp;
    } vec_t;

    localparam int NumVec = 25;
    vec_t vecs [NumVec];

    task automatic drive(input logic [1:0] a, input logic mr, input logic [1:0] m,
                         input logic fc);
        bus.auto_girar   = a[1];
        bus.auto_avancar = a[0];
        bus.man_req      = mr;
        bus.man_girar    = m[1];
        bus.man_avancar  = m[0];
        bus.fault_clr    = fc;
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic check(input string name, input logic [3:0] exp);
        logic [3:0] got;
        got = {bus.man_grant, bus.fault, bus.motor_rot, bus.motor_fwd};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got {grant,fault,rot,fwd}=%b expected %b", name, got, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{2'b01, 1'b0, 2'b00, 1'b0, 4'b0000};  // IDLE -> AUTO
        vecs[1]  = '{2'b01, 1'b0, 2'b00, 1'b0, 4'b0001};  // fwd appears
        vecs[2]  = '{2'b10, 1'b0, 2'b00, 1'b0, 4'b0001};
        vecs[3]  = '{2'b01, 1'b0, 2'b00, 1'b0, 4'b0001};
        vecs[4]  = '{2'b10, 1'b0, 2'b00, 1'b0, 4'b0001};
        vecs[5]  = '{2'b10, 1'b0, 2'b00, 1'b0, 4'b0010};  // dwell expired
        vecs[6]  = '{2'b01, 1'b0, 2'b00, 1'b0, 4'b0010};
        vecs[7]  = '{2'b11, 1'b0, 2'b00, 1'b0, 4'b0010};
        vecs[8]  = '{2'b11, 1'b0, 2'b00, 1'b0, 4'b0010};
        vecs[9]  = '{2'b11, 1'b0, 2'b00, 1'b0, 4'b0000};  // illegal -> stop
        vecs[10] = '{2'b01, 1'b0, 2'b00, 1'b0, 4'b0000};
        vecs[11] = '{2'b01, 1'b0, 2'b00, 1'b0, 4'b0000};
        vecs[12] = '{2'b01, 1'b0, 2'b00, 1'b0, 4'b0000};
        vecs[13] = '{2'b01, 1'b0, 2'b00, 1'b0, 4'b0001};
        vecs[14] = '{2'b01, 1'b1, 2'b10, 1'b0, 4'b0000};  // BRAKE
        vecs[15] = '{2'b01, 1'b1, 2'b10, 1'b0, 4'b1000};  // MANUAL granted
        vecs[16] = '{2'b01, 1'b1, 2'b10, 1'b0, 4'b1010};
        vecs[17] = '{2'b01, 1'b1, 2'b11, 1'b0, 4'b1010};
        vecs[18] = '{2'b01, 1'b1, 2'b11, 1'b0, 4'b1010};
        vecs[19] = '{2'b01, 1'b1, 2'b11, 1'b0, 4'b1010};
        vecs[20] = '{2'b01, 1'b1, 2'b11, 1'b0, 4'b1000};
        vecs[21] = '{2'b10, 1'b0, 2'b00, 1'b0, 4'b0000};  // BRAKE on release
        vecs[22] = '{2'b10, 1'b0, 2'b00, 1'b0, 4'b0000};
        vecs[23] = '{2'b10, 1'b0, 2'b00, 1'b0, 4'b0010};
        vecs[24] = '{2'b10, 1'b0, 2'b00, 1'b1, 4'b0010};  // clear ignored outside FAULT

        reset = 1'b1;
        drive(2'b00, 1'b0, 2'b00, 1'b0);
        #12;
        check("reset_state", 4'b0000);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < NumVec; i++) begin
            drive(vecs[i].auto_cmd, vecs[i].man_req, vecs[i].man_cmd, vecs[i].fault_clr);
            step();
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Rotation has been driven for one edge; expiry lands 63 edges later, together with
        // a manual request that must lose.
        for (int i = 1; i <= 63; i++) begin
            drive(2'b10, (i == 63), 2'b01, 1'b0);
            step();
            check($sformatf("wd%0d", i), (i == 63) ? 4'b0100 : 4'b0010);
        end

        for (int i = 0; i < 3; i++) begin
            drive(2'b10, 1'b1, 2'b01, 1'b0);
            step();
            check($sformatf("fault_hold%0d", i), 4'b0100);
        end

        drive(2'b10, 1'b0, 2'b00, 1'b1);
        step();
        check("fault_clr", 4'b0000);

        drive(2'b10, 1'b1, 2'b10, 1'b0);
        step();
        check("idle_to_manual", 4'b1000);
        step();
        check("manual_rot", 4'b1010);

        #2;
        reset = 1'b1;
        #1;
        check("async_reset", 4'b0000);
        step();
        check("reset_hold", 4'b0000);
        reset = 1'b0;

        drive(2'b01, 1'b0, 2'b00, 1'b0);
        step();
        check("post_reset_auto", 4'b0000);
        step();
        check("post_reset_fwd", 4'b0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
